// File: rtl/wb_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_ram_arbiter: shares one Wishbone RAM slave port among NUM_MASTERS      |
// | masters, whole-cycle ownership, round-robin, per-access ERR watchdog.     |
// | Option ARB_VIDEO_IN_PRIO_EN: master 0 (video_in) wins every arbitration.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module wb_ram_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                      p_clk,
  input  logic                      p_reset,
  input  logic [NUM_MASTERS-1:0]    m_wb_CYC_I,
  input  logic [NUM_MASTERS-1:0]    m_wb_STB_I,
  input  logic [NUM_MASTERS-1:0]    m_wb_WE_I,
  input  logic [NUM_MASTERS-1:0]    m_wb_LOCK_I,
  input  logic [4*NUM_MASTERS-1:0]  m_wb_SEL_I,
  input  logic [32*NUM_MASTERS-1:0] m_wb_ADR_I,
  input  logic [32*NUM_MASTERS-1:0] m_wb_DAT_I,
  output logic [31:0]               m_wb_DAT_O,
  output logic [NUM_MASTERS-1:0]    m_wb_ACK_O,
  output logic [NUM_MASTERS-1:0]    m_wb_ERR_O,
  output logic [NUM_MASTERS-1:0]    m_wb_RTY_O,
  output logic                      s_wb_CYC_O,
  output logic                      s_wb_STB_O,
  output logic                      s_wb_WE_O,
  output logic                      s_wb_LOCK_O,
  output logic [3:0]                s_wb_SEL_O,
  output logic [31:0]               s_wb_ADR_O,
  output logic [31:0]               s_wb_DAT_O,
  input  logic [31:0]               s_wb_DAT_I,
  input  logic                      s_wb_ACK_I,
  input  logic                      s_wb_ERR_I,
  input  logic                      s_wb_RTY_I,
  output logic [NUM_MASTERS-1:0]    grant
);

  localparam int IW = (NUM_MASTERS > 2) ? 2 : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [IW-1:0]          last, last_nxt;
  logic [IW-1:0]          owner, pick, scan_idx;
  logic                   pick_valid;
  logic [7:0]             wdog, wdog_nxt;
  logic                   owned, resp, wd_hit, wd_err;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant[i]) owner = IW'(i);
  end

  // Scan downwards so the last hit is the nearest requester after 'last'.
  always_comb begin
    pick       = last;
    pick_valid = 1'b0;
    scan_idx   = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      scan_idx = IW'((int'(last) + k) % NUM_MASTERS);
      if (m_wb_CYC_I[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
`ifdef ARB_VIDEO_IN_PRIO_EN
    if (m_wb_CYC_I[0]) begin
      pick       = '0;
      pick_valid = 1'b1;
    end
`endif
  end

  assign owned       = |grant;
  assign resp        = s_wb_ACK_I | s_wb_ERR_I | s_wb_RTY_I;
  // STB is cut on the timeout cycle unconditionally so it never depends on
  // the slave's response (no combinational loop through a fast slave).
  assign wd_hit      = owned && (wdog == 8'(TIMEOUT));
  assign wd_err      = wd_hit & ~resp;

  assign s_wb_CYC_O  = owned & m_wb_CYC_I[owner];
  assign s_wb_STB_O  = owned & m_wb_STB_I[owner] & ~wd_hit;
  assign s_wb_WE_O   = owned & m_wb_WE_I[owner];
  assign s_wb_LOCK_O = owned & m_wb_LOCK_I[owner];
  assign s_wb_SEL_O  = owned ? m_wb_SEL_I[owner*4 +: 4]  : 4'hF;
  assign s_wb_ADR_O  = owned ? m_wb_ADR_I[owner*32 +: 32] : 32'h0;
  assign s_wb_DAT_O  = owned ? m_wb_DAT_I[owner*32 +: 32] : 32'h0;

  assign m_wb_DAT_O  = s_wb_DAT_I;
  assign m_wb_ACK_O  = grant & {NUM_MASTERS{s_wb_ACK_I}};
  assign m_wb_ERR_O  = grant & {NUM_MASTERS{s_wb_ERR_I | wd_err}};
  assign m_wb_RTY_O  = grant & {NUM_MASTERS{s_wb_RTY_I}};

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    wdog_nxt  = '0;
    if (s_wb_STB_O && !resp) wdog_nxt = wdog + 8'd1;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick;
          state_nxt = OWNED;
        end
      end
      OWNED: begin
        if (!m_wb_CYC_I[owner] && !m_wb_LOCK_I[owner]) begin
          grant_nxt = '0;
          state_nxt = IDLE;
`ifdef ARB_VIDEO_IN_PRIO_EN
          if (owner != '0) last_nxt = owner;
`else
          last_nxt = owner;
`endif
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(NUM_MASTERS - 1);
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      wdog  <= wdog_nxt;
    end
  end

endmodule
`default_nettype wire
